// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub
//  Purpose  : Bit-serial WIDTH-bit adder/subtractor built on one reused
//             full-adder cell, with carry/overflow flags and start/busy/done.
//  Revision : 1.0  initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_shift_cat;

    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_run       = (r_state == c_RUN);
    assign w_last      = w_run && (r_cnt == c_LAST_BIT);

    // The single full-adder cell: half-adder pair plus majority carry.
    assign w_s         = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_c         = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));

    // The shift register holds WIDTH-1 bits; the final bit completes the word.
    assign w_shift_cat = {w_s, r_shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_RUN) || (r_state == c_DONE);
        done = (r_state == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= w_shift_cat[WIDTH-1:1];
            if (w_last) begin
                // r_carry here is still the carry into the MSB.
                r_sum       <= w_shift_cat;
                r_carry_out <= w_c;
                r_overflow  <= r_carry ^ w_c;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor, built around one full-adder cell (half-adder pair plus carry flop) that is reused every cycle.
- Successor to the combinational single-bit adder cells: it handles WIDTH-bit operands with add/subtract mode, carry/overflow flags and a start/busy/done handshake.
- Intended for area- and power-constrained datapaths where one result per WIDTH+2 cycles is acceptable.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b (two's complement); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- sum  output  WIDTH  result; held until the next accepted start.
- carry_out  output  1  final carry. For subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- Reset:
  - On any clk edge with rst=1: state=IDLE; sum=0, carry_out=0, overflow=0, busy=0, done=0.
  - Shift registers, carry flop and counter are cleared.
  - rst has priority over start.
  - rst mid-operation aborts it: no done pulse, and sum returns to 0.
- States:
  - IDLE -> RUN on edge E0 with start=1.
  - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE on the next edge, unconditionally.
- Load at E0:
  - opa <= a.
  - opb <= (sub ? ~b : b).
  - carry <= sub.
  - cnt <= 0.
  - busy=1 from E0 onward.
- RUN, edges E1..E_WIDTH (edge Ei processes bit i-1):
  - s = opa[0]^opb[0]^carry; c = majority(opa[0], opb[0], carry).
  - s shifts into the result shift register MSB-first, so after WIDTH shifts bit 0 sits at LSB.
  - opa and opb shift right by one; carry <= c; cnt increments.
  - At the bit WIDTH-1 step, additionally capture cin_msb = carry (before update) and cout = c.
- Edge E_WIDTH:
  - sum, carry_out and overflow update atomically.
  - overflow = cin_msb ^ cout.
  - state=DONE, done=1.
- Edge E_WIDTH+1: done=0, busy=0, state=IDLE.
- Throughput: next start is accepted no earlier than edge E_WIDTH+2.
- Timing: latency from accepted start to done high is WIDTH edges.
- start ignored outside IDLE:
  - In RUN and DONE, start, a, b and sub are ignored and have no effect.
  - No queueing: a start ignored in RUN/DONE is dropped.
- Outputs:
  - sum, carry_out and overflow change only at E_WIDTH or on reset.
  - They are stable at all other times, including across IDLE cycles.
- Power: operand registers hold (no shifting, no toggling) in IDLE and DONE.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - carry_out equals bit WIDTH of the (WIDTH+1)-bit sum of a + (sub ? ~b : b) + sub.

Test Plan (WIDTH=8):
- Add, no carry: a=0x0F, b=0x01, sub=0 -> after 8 edges sum=0x10, carry_out=0, overflow=0, done high exactly one cycle, busy high 9 cycles.
- Wrap and overflow:
  - a=0xFF, b=0x01, add -> sum=0x00, carry_out=1, overflow=0.
  - a=0x7F, b=0x01, add -> sum=0x80, carry_out=0, overflow=1.
- Subtract:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0, overflow=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, carry_out=1, overflow=1.
- start while busy: start=1 with a=0x01, b=0x01 at E0; then start=1 with a=0x10, b=0x10 at E3 and at E_WIDTH+1 -> single result 0x02, one done pulse.
- Reset mid-op: rst=1 at E4 of an add -> next cycle busy=0, done=0, sum=0. Subsequent op 0x03+0x04 -> 0x07 with normal latency.
- Randomised: 200 random a/b/sub, each checked against the reference model (a ± b, carry, signed overflow). Also repeat the directed cases at WIDTH=2 and WIDTH=32.
